// File: rtl/axi_lite_cmd_master_if.sv
// AXI4-Lite bus bundle (32-bit address/data) shared by the command master
// and the memory wrapper.
interface axi4_lite_if;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport m (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport s (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: one valid/ready command in, one
// response out, with a timeout that answers for slaves that never respond.
module axi_lite_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        rsp_timeout,
    axi4_lite_if.m      axi
);

    localparam int unsigned     CNT_W      = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic            TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, RSP, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic             closed_q, closed_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             awvalid_q, awvalid_d;
    logic             wvalid_q, wvalid_d;
    logic             arvalid_q, arvalid_d;
    logic             bready_q, bready_d;
    logic             rready_q, rready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic [1:0]       rsp_resp_q, rsp_resp_d;
    logic             rsp_timeout_q, rsp_timeout_d;

    logic             cmd_accept, aw_hs, w_hs, ar_hs, b_hs, r_hs, rsp_hs;
    logic             aw_done, w_done, ar_done, timeout_hit, raise_timeout;
    logic [CNT_W-1:0] cnt_inc;

    assign cmd_accept  = (state_q == IDLE) && cmd_valid && cmd_ready_q;
    assign aw_hs       = awvalid_q && axi.awready;
    assign w_hs        = wvalid_q && axi.wready;
    assign ar_hs       = arvalid_q && axi.arready;
    assign b_hs        = bready_q && axi.bvalid;
    assign r_hs        = rready_q && axi.rvalid;
    assign rsp_hs      = rsp_valid_q && rsp_ready;
    assign aw_done     = !awvalid_q || axi.awready;
    assign w_done      = !wvalid_q || axi.wready;
    assign ar_done     = !arvalid_q || axi.arready;
    assign cnt_inc     = cnt_q + CNT_W'(1);
    // Fires in the cycle whose increment lands on the limit, so the response is
    // registered one cycle later at TIMEOUT_CYCLES+1 after acceptance.
    assign timeout_hit = TIMEOUT_EN && (cnt_inc == CNT_LIMIT);

    // Next-state and registered-output computation.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        we_d          = we_q;
        closed_d      = closed_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        cmd_ready_d   = 1'b0;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        arvalid_d     = arvalid_q;
        bready_d      = bready_q;
        rready_d      = rready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        raise_timeout = 1'b0;

        unique case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_accept) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    wstrb_d     = cmd_wstrb;
                    we_d        = cmd_we;
                    cnt_d       = '0;
                    closed_d    = 1'b0;
                    if (cmd_we) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WADDR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RADDR;
                    end
                end
            end
            WADDR: begin
                cnt_d = cnt_inc;
                if (aw_hs) awvalid_d = 1'b0;
                if (w_hs)  wvalid_d  = 1'b0;
                if (timeout_hit) begin
                    raise_timeout = 1'b1;
                end else if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = WRESP;
                end
            end
            WRESP: begin
                cnt_d = cnt_inc;
                if (b_hs) begin
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = axi.bresp;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b0;
                    state_d       = RSP;
                end else if (timeout_hit) begin
                    raise_timeout = 1'b1;
                end
            end
            RADDR: begin
                cnt_d = cnt_inc;
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
                if (timeout_hit) begin
                    raise_timeout = 1'b1;
                end else if (ar_hs) begin
                    state_d = RDATA;
                end
            end
            RDATA: begin
                cnt_d = cnt_inc;
                if (r_hs) begin
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = axi.rresp;
                    rsp_rdata_d   = axi.rdata;
                    rsp_timeout_d = 1'b0;
                    state_d       = RSP;
                end else if (timeout_hit) begin
                    raise_timeout = 1'b1;
                end
            end
            RSP: begin
                if (rsp_hs) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            DRAIN: begin
                // Finish the abandoned AXI transaction without ever withdrawing a
                // valid; the late response is accepted and dropped.
                if (rsp_hs) rsp_valid_d = 1'b0;
                if (we_q) begin
                    if (aw_hs) awvalid_d = 1'b0;
                    if (w_hs)  wvalid_d  = 1'b0;
                    if (b_hs) begin
                        bready_d = 1'b0;
                        closed_d = 1'b1;
                    end else if (aw_done && w_done && !closed_q) begin
                        bready_d = 1'b1;
                    end
                end else begin
                    if (ar_hs) arvalid_d = 1'b0;
                    if (r_hs) begin
                        rready_d = 1'b0;
                        closed_d = 1'b1;
                    end else if (ar_done && !closed_q) begin
                        rready_d = 1'b1;
                    end
                end
                if ((closed_q || b_hs || r_hs) && (!rsp_valid_q || rsp_ready)) begin
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (raise_timeout) begin
            rsp_valid_d   = 1'b1;
            rsp_resp_d    = 2'b10;
            rsp_rdata_d   = '0;
            rsp_timeout_d = 1'b1;
            state_d       = DRAIN;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            we_q          <= 1'b0;
            closed_q      <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            cmd_ready_q   <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            bready_q      <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            we_q          <= we_d;
            closed_q      <= closed_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            cmd_ready_q   <= cmd_ready_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            arvalid_q     <= arvalid_d;
            bready_q      <= bready_d;
            rready_q      <= rready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;
    assign rsp_timeout = rsp_timeout_q;

    assign axi.awaddr  = addr_q;
    assign axi.araddr  = addr_q;
    assign axi.awprot  = '0;
    assign axi.arprot  = '0;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.awvalid = awvalid_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.arvalid = arvalid_q;
    assign axi.bready  = bready_q;
    assign axi.rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master: a zero-wait memory slave for normal
// traffic and hand-driven slave handshakes for skew, timeout and reset cases.
module tb_axi_lite_cmd_master;

    logic        clk;
    logic        areset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;

    logic        manual;
    logic        m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
    logic [1:0]  m_bresp, m_rresp;
    logic [31:0] m_rdata;

    logic        s_bvalid, s_rvalid;
    logic [31:0] s_rdata;
    logic [31:0] mem [0:63];

    int n_assert = 0;
    int n_fail   = 0;
    int lat;

    axi4_lite_if axi_bus ();

    assign axi_bus.awready = manual ? m_awready : 1'b1;
    assign axi_bus.wready  = manual ? m_wready  : 1'b1;
    assign axi_bus.arready = manual ? m_arready : 1'b1;
    assign axi_bus.bvalid  = manual ? m_bvalid  : s_bvalid;
    assign axi_bus.bresp   = manual ? m_bresp   : 2'b00;
    assign axi_bus.rvalid  = manual ? m_rvalid  : s_rvalid;
    assign axi_bus.rdata   = manual ? m_rdata   : s_rdata;
    assign axi_bus.rresp   = manual ? m_rresp   : 2'b00;

    axi_lite_cmd_master #(.TIMEOUT_CYCLES(16)) dut (
        .aclk        (clk),
        .areset      (areset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_we      (cmd_we),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_wstrb   (cmd_wstrb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_resp    (rsp_resp),
        .rsp_timeout (rsp_timeout),
        .axi         (axi_bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Zero-wait memory slave: always ready, responds the cycle after the handshake.
    always @(posedge clk) begin
        if (areset || manual) begin
            s_bvalid <= 1'b0;
            s_rvalid <= 1'b0;
        end else begin
            if (s_bvalid && axi_bus.bready) begin
                s_bvalid <= 1'b0;
            end else if (axi_bus.awvalid && axi_bus.wvalid) begin
                for (int i = 0; i < 4; i++)
                    if (axi_bus.wstrb[i]) mem[axi_bus.awaddr[7:2]][8*i +: 8] <= axi_bus.wdata[8*i +: 8];
                s_bvalid <= 1'b1;
            end
            if (s_rvalid && axi_bus.rready) begin
                s_rvalid <= 1'b0;
            end else if (axi_bus.arvalid) begin
                s_rdata  <= mem[axi_bus.araddr[7:2]];
                s_rvalid <= 1'b1;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one command for one cycle; returns in cycle 1 after acceptance.
    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        chk("cmd_ready_before_cmd", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
        tick;
        cmd_valid = 1'b0;
    endtask

    task automatic send(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output int latency);
        issue(we, a, d, s);
        latency = 1;
        while (rsp_valid !== 1'b1 && latency < 64) begin
            tick;
            latency++;
        end
    endtask

    task automatic take;
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        chk("rsp_consumed", 64'({rsp_valid, cmd_ready}), 64'b01);
    endtask

    task automatic skew_write(input string tag, input int aw_cyc, input int w_cyc, input logic [1:0] bresp);
        int last;
        last = (aw_cyc > w_cyc) ? aw_cyc : w_cyc;
        issue(1'b1, 32'h50, 32'h0BADF00D, 4'b0011);
        chk({tag, "_payload"}, {axi_bus.awaddr, axi_bus.wdata}, {32'h50, 32'h0BADF00D});
        for (int c = 1; c <= last + 1; c++) begin
            chk({tag, "_valids"}, 64'({axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready, rsp_valid}),
                64'({(c <= aw_cyc), (c <= w_cyc), (c == last + 1), 1'b0}));
            m_awready = (c == aw_cyc);
            m_wready  = (c == w_cyc);
            m_bvalid  = (c == last + 1);
            m_bresp   = bresp;
            tick;
        end
        m_awready = 1'b0;
        m_wready  = 1'b0;
        m_bvalid  = 1'b0;
        chk({tag, "_rsp"}, 64'({rsp_valid, axi_bus.bready, rsp_resp, rsp_timeout, rsp_rdata}),
            64'({1'b1, 1'b0, bresp, 1'b0, 32'h0}));
        take;
    endtask

    initial begin
        areset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_wstrb = '0;
        rsp_ready = 1'b0;
        manual    = 1'b0;
        m_awready = 1'b0;
        m_wready  = 1'b0;
        m_bvalid  = 1'b0;
        m_bresp   = 2'b00;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rdata   = '0;
        m_rresp   = 2'b00;

        // Reset state
        tick; tick; tick;
        chk("reset_ctrl", 64'({cmd_ready, rsp_valid, rsp_timeout, rsp_resp, axi_bus.awvalid, axi_bus.wvalid,
                               axi_bus.arvalid, axi_bus.bready, axi_bus.rready}), 64'd0);
        chk("reset_data", {axi_bus.awaddr, axi_bus.wdata}, 64'd0);
        chk("reset_rdata", 64'({axi_bus.araddr, axi_bus.wstrb, rsp_rdata}), 64'd0);
        areset = 1'b0;
        tick;
        chk("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);

        // Write then read, zero-wait slave
        send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat);
        chk("wr_latency", 64'(lat), 64'd3);
        chk("wr_rsp", 64'({rsp_resp, rsp_timeout, rsp_rdata}), 64'({2'b00, 1'b0, 32'h0}));
        take;
        send(1'b0, 32'h10, 32'h0, 4'h0, lat);
        chk("rd_latency", 64'(lat), 64'd3);
        chk("rd_rsp", 64'({rsp_resp, rsp_timeout, rsp_rdata}), 64'({2'b00, 1'b0, 32'hDEADBEEF}));
        take;

        // Partial strobe
        send(1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, lat);
        take;
        send(1'b1, 32'h20, 32'h00000000, 4'b0101, lat);
        take;
        send(1'b0, 32'h20, 32'h0, 4'h0, lat);
        chk("strobe_rdata", 64'(rsp_rdata), 64'hFF00FF00);
        take;

        // Channel skew
        manual = 1'b1;
        skew_write("skew_w_first", 6, 1, 2'b00);
        skew_write("skew_aw_first", 1, 6, 2'b01);
        skew_write("skew_same", 3, 3, 2'b11);

        // Timeout and drain: arready withheld until cycle 30, rvalid at 32
        issue(1'b0, 32'h60, 32'h0, 4'h0);
        for (int c = 1; c <= 32; c++) begin
            if (c == 16) chk("to_not_yet", 64'(rsp_valid), 64'd0);
            if (c == 17) chk("to_rsp", 64'({rsp_valid, rsp_resp, rsp_timeout, axi_bus.arvalid, cmd_ready, rsp_rdata}),
                             64'({1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 32'h0}));
            if (c == 21) chk("to_consumed", 64'({rsp_valid, cmd_ready, axi_bus.arvalid}), 64'b001);
            if (c == 29) chk("to_ar_held", 64'({axi_bus.arvalid, axi_bus.rready, cmd_ready}), 64'b100);
            if (c == 31) chk("to_ar_done", 64'({axi_bus.arvalid, axi_bus.rready, cmd_ready}), 64'b010);
            rsp_ready = (c == 20);
            m_arready = (c == 30);
            m_rvalid  = (c == 32);
            m_rdata   = 32'hCAFEF00D;
            tick;
        end
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        chk("to_drained", 64'({rsp_valid, axi_bus.rready, cmd_ready}), 64'b001);
        manual = 1'b0;
        send(1'b0, 32'h10, 32'h0, 4'h0, lat);
        chk("after_drain_rd", 64'({rsp_timeout, rsp_rdata}), 64'({1'b0, 32'hDEADBEEF}));
        take;

        // Reset during WRESP
        manual = 1'b1;
        issue(1'b1, 32'h70, 32'h11223344, 4'hF);
        m_awready = 1'b1;
        m_wready  = 1'b1;
        tick;
        m_awready = 1'b0;
        m_wready  = 1'b0;
        chk("rst_in_wresp", 64'(axi_bus.bready), 64'd1);
        areset = 1'b1;
        tick;
        chk("rst_mid_ctrl", 64'({cmd_ready, rsp_valid, rsp_timeout, rsp_resp, axi_bus.awvalid, axi_bus.wvalid,
                                 axi_bus.arvalid, axi_bus.bready, axi_bus.rready}), 64'd0);
        chk("rst_mid_data", {axi_bus.awaddr, axi_bus.wdata}, 64'd0);
        chk("rst_mid_rdata", 64'({axi_bus.wstrb, rsp_rdata}), 64'd0);
        areset = 1'b0;
        manual = 1'b0;
        tick;
        chk("cmd_ready_after_rst_mid", 64'(cmd_ready), 64'd1);
        send(1'b1, 32'h70, 32'h11223344, 4'hF, lat);
        chk("post_rst_wr", 64'({lat[7:0], rsp_resp, rsp_timeout}), 64'({8'd3, 2'b00, 1'b0}));
        take;
        send(1'b0, 32'h70, 32'h0, 4'h0, lat);
        chk("post_rst_rd", 64'(rsp_rdata), 64'h11223344);
        take;

        // Response backpressure
        send(1'b1, 32'h30, 32'h12345678, 4'hF, lat);
        take;
        send(1'b0, 32'h30, 32'h0, 4'h0, lat);
        chk("bp_first", 64'({rsp_valid, cmd_ready, rsp_timeout, rsp_resp, rsp_rdata}),
            64'({1'b1, 1'b0, 1'b0, 2'b00, 32'h12345678}));
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("bp_hold", 64'({rsp_valid, cmd_ready, rsp_timeout, rsp_resp, rsp_rdata}),
                64'({1'b1, 1'b0, 1'b0, 2'b00, 32'h12345678}));
        end
        take;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
